// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter sharing the single regfile write port between the ALU (ch0) and LSU (ch1).
// Round-robin under contention, one registered output stage, pending-write mask for decode hazards.
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    hold,
  input  logic                    valid0,
  input  logic [$clog2(NREG)-1:0] addr0,
  input  logic [XLEN-1:0]         data0,
  output logic                    ready0,
  input  logic                    valid1,
  input  logic [$clog2(NREG)-1:0] addr1,
  input  logic [XLEN-1:0]         data1,
  output logic                    ready1,
  output logic                    rf_we,
  output logic [$clog2(NREG)-1:0] rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic [NREG-1:0]         pending_mask,
  output logic                    grant_ptr
);

  localparam int AW = $clog2(NREG);
  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  logic            fire0;
  logic            fire1;
  logic            contend;
  logic [AW-1:0]   win_addr;
  logic [XLEN-1:0] win_data;

  // Under contention only the channel named by grant_ptr is offered ready.
  always_comb begin
    ready0 = ~hold & valid0 & (~valid1 | ~grant_ptr);
    ready1 = ~hold & valid1 & (~valid0 | grant_ptr);
  end

  assign fire0   = valid0 & ready0;
  assign fire1   = valid1 & ready1;
  assign contend = valid0 & valid1 & (fire0 | fire1);

  always_comb begin
    win_addr = addr0;
    win_data = data0;
    if (fire1) begin
      win_addr = addr1;
      win_data = data1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      pending_mask <= '0;
      grant_ptr    <= 1'b0;
    end else begin
      if (fire0 | fire1) begin
        rf_waddr     <= win_addr;
        rf_wdata     <= win_data;
        // x0 writes complete the handshake but never reach the regfile.
        rf_we        <= (win_addr != '0);
        pending_mask <= (win_addr != '0) ? (ONE << win_addr) : '0;
      end else begin
        rf_we        <= 1'b0;
        pending_mask <= '0;
      end
      if (contend) grant_ptr <= ~grant_ptr;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a small regfile model fed by the write port.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic        valid0, valid1;
  logic [4:0]  addr0, addr1;
  logic [31:0] data0, data1;
  logic        ready0, ready1;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending_mask;
  logic        grant_ptr;

  logic [31:0] rf [32];
  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .valid0(valid0), .addr0(addr0), .data0(data0), .ready0(ready0),
    .valid1(valid1), .addr1(addr1), .data1(data1), .ready1(ready1),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending_mask(pending_mask), .grant_ptr(grant_ptr)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rf_we && rf_waddr != 5'd0) rf[rf_waddr] <= rf_wdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rst_n = 1'b0; hold = 1'b0;
    valid0 = 1'b0; addr0 = '0; data0 = '0;
    valid1 = 1'b0; addr1 = '0; data1 = '0;
    step(); step();
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_mask", pending_mask, 0);
    chk("rst_ptr", grant_ptr, 0);
    rst_n = 1'b1;

    // single ALU write to x5
    valid0 = 1'b1; addr0 = 5'd5; data0 = 32'hDEADBEEF;
    #1;
    chk("single_rdy0", ready0, 1);
    chk("single_rdy1", ready1, 0);
    step();
    valid0 = 1'b0;
    chk("single_we", rf_we, 1);
    chk("single_waddr", rf_waddr, 5);
    chk("single_wdata", rf_wdata, 32'hDEADBEEF);
    chk("single_mask", pending_mask, 32'h0000_0020);
    chk("single_ptr", grant_ptr, 0);
    step();
    chk("single_we_off", rf_we, 0);
    chk("single_mask_off", pending_mask, 0);
    chk("single_waddr_hold", rf_waddr, 5);
    chk("single_x5", rf[5], 32'hDEADBEEF);

    // contention: ALU, LSU, ALU, LSU
    valid0 = 1'b1; addr0 = 5'd3; data0 = 32'hA0A0_0003;
    valid1 = 1'b1; addr1 = 5'd4; data1 = 32'hB1B1_0004;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cont_rdy0", ready0, (k % 2 == 0));
      chk("cont_rdy1", ready1, (k % 2 == 1));
      step();
      chk("cont_waddr", rf_waddr, (k % 2 == 0) ? 3 : 4);
      chk("cont_wdata", rf_wdata, (k % 2 == 0) ? 32'hA0A0_0003 : 32'hB1B1_0004);
      chk("cont_mask", pending_mask, (k % 2 == 0) ? 32'h8 : 32'h10);
      chk("cont_ptr", grant_ptr, (k % 2 == 0));
    end
    valid0 = 1'b0; valid1 = 1'b0;
    step();
    chk("cont_x3", rf[3], 32'hA0A0_0003);
    chk("cont_x4", rf[4], 32'hB1B1_0004);

    // x0 drop on LSU
    valid1 = 1'b1; addr1 = 5'd0; data1 = 32'h12345678;
    #1;
    chk("x0_rdy1", ready1, 1);
    step();
    valid1 = 1'b0;
    chk("x0_we", rf_we, 0);
    chk("x0_mask", pending_mask, 0);
    chk("x0_waddr", rf_waddr, 0);
    chk("x0_wdata", rf_wdata, 32'h12345678);

    // hold refuses both for 3 cycles
    hold = 1'b1;
    valid0 = 1'b1; addr0 = 5'd10; data0 = 32'hC0C0_000A;
    valid1 = 1'b1; addr1 = 5'd11; data1 = 32'hD0D0_000B;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_rdy0", ready0, 0);
      chk("hold_rdy1", ready1, 0);
      step();
      chk("hold_we", rf_we, 0);
      chk("hold_ptr", grant_ptr, 0);
    end
    hold = 1'b0;
    #1;
    chk("unhold_rdy0", ready0, 1);
    chk("unhold_rdy1", ready1, 0);
    step();
    chk("unhold_we", rf_we, 1);
    chk("unhold_waddr", rf_waddr, 10);
    chk("unhold_ptr", grant_ptr, 1);

    // same address x7, LSU preferred
    addr0 = 5'd7; data0 = 32'h1;
    addr1 = 5'd7; data1 = 32'h2;
    #1;
    chk("same_rdy0", ready0, 0);
    chk("same_rdy1", ready1, 1);
    step();
    valid1 = 1'b0;
    chk("same1_wdata", rf_wdata, 32'h2);
    chk("same1_mask", pending_mask, 32'h80);
    chk("same1_ptr", grant_ptr, 0);
    #1;
    chk("same2_rdy0", ready0, 1);
    step();
    valid0 = 1'b0;
    chk("same2_wdata", rf_wdata, 32'h1);
    chk("same2_ptr", grant_ptr, 0);
    chk("same_x7_mid", rf[7], 32'h2);
    step();
    chk("same_x7_final", rf[7], 32'h1);
    chk("same_we_off", rf_we, 0);

    // reset mid-transfer discards the in-flight write
    valid0 = 1'b1; addr0 = 5'd9;  data0 = 32'h9999_0009;
    valid1 = 1'b1; addr1 = 5'd12; data1 = 32'hCCCC_000C;
    step();
    valid1 = 1'b0;
    chk("mid_we", rf_we, 1);
    chk("mid_ptr", grant_ptr, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we", rf_we, 0);
    chk("arst_waddr", rf_waddr, 0);
    chk("arst_wdata", rf_wdata, 0);
    chk("arst_mask", pending_mask, 0);
    chk("arst_ptr", grant_ptr, 0);
    step();
    chk("arst_hold_we", rf_we, 0);
    valid0 = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_we", rf_we, 0);
    chk("post_rst_ptr", grant_ptr, 0);
    chk("post_rst_x9", rf[9], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
